multiple_word_sequencer: RTL and testbench

//  Sits between the D-format decoder and issue. Passes ordinary D-format ops through with 1-cycle latency.

---
 rtl/multiple_word_sequencer.sv | 115 +++++++++++
 tb/tb_multiple_word_sequencer.sv | 100 ++++++++++
 2 files changed

// File: rtl/multiple_word_sequencer.sv
// multiple_word_sequencer: passes D-form ops through, expands lmw/stmw into per-register micro-ops, stalls decode meanwhile
module multiple_word_sequencer #(
  parameter int opcodeWidth = 6,
  parameter int regWidth    = 5,
  parameter int immWidth    = 16,
  parameter logic [1:0] regRead  = 2'd1,
  parameter logic [1:0] regWrite = 2'd2
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  input  logic [opcodeWidth-1:0] opcode_i,
  input  logic [regWidth-1:0]    reg1_i,
  input  logic [regWidth-1:0]    reg2_i,
  input  logic [1:0]             reg1Use_i,
  input  logic [1:0]             reg2Use_i,
  input  logic                   reg2ValOrZero_i,
  input  logic [immWidth-1:0]    imm_i,
  input  logic                   stall_i,
  output logic                   stall_o,
  output logic                   enable_o,
  output logic [regWidth-1:0]    reg1_o,
  output logic [regWidth-1:0]    reg2_o,
  output logic [1:0]             reg1Use_o,
  output logic [1:0]             reg2Use_o,
  output logic                   reg2ValOrZero_o,
  output logic [immWidth-1:0]    imm_o,
  output logic                   lastUop_o,
  output logic                   illegal_o
);
  typedef enum logic {IDLE, SEQ} state_t;
  localparam logic [opcodeWidth-1:0] OP_LMW  = opcodeWidth'(46);
  localparam logic [opcodeWidth-1:0] OP_STMW = opcodeWidth'(47);
  localparam logic [regWidth-1:0]    REG_MAX = '1;
  state_t                r_state, w_state;
  logic                  r_en, w_en, r_z, w_z, r_last, w_last, r_ill, w_ill;
  logic [regWidth-1:0]   r_reg1, w_reg1, r_reg2, w_reg2;
  logic [1:0]            r_u1, w_u1, r_u2, w_u2;
  logic [immWidth-1:0]   r_imm, w_imm;
  logic                  w_accept, w_multi, w_lmw, w_bad;
  assign stall_o         = stall_i | (r_en & ~r_last);
  assign w_accept        = enable_i & ~stall_o;
  assign w_lmw           = opcode_i == OP_LMW;
  assign w_multi         = w_lmw | (opcode_i == OP_STMW);
  assign w_bad           = w_lmw & (reg2_i != '0) & (reg2_i >= reg1_i);
  assign enable_o        = r_en;
  assign reg1_o          = r_reg1;
  assign reg2_o          = r_reg2;
  assign reg1Use_o       = r_u1;
  assign reg2Use_o       = r_u2;
  assign reg2ValOrZero_o = r_z;
  assign imm_o           = r_imm;
  assign lastUop_o       = r_last;
  assign illegal_o       = r_ill;
  always_comb begin
    w_state = r_state;
    w_en    = r_en;
    w_reg1  = r_reg1;
    w_reg2  = r_reg2;
    w_u1    = r_u1;
    w_u2    = r_u2;
    w_z     = r_z;
    w_imm   = r_imm;
    w_last  = r_last;
    w_ill   = r_ill;
    if (!stall_i) begin
      w_en  = 1'b0;
      w_ill = 1'b0;
      if (r_state == SEQ) begin
        w_en    = 1'b1;
        w_reg1  = r_reg1 + 1'b1;
        w_imm   = r_imm + immWidth'(4);
        w_last  = w_reg1 == REG_MAX;
        w_state = w_last ? IDLE : SEQ;
      end else if (w_accept && w_multi && w_bad) begin
        w_ill = 1'b1;
      end else if (w_accept) begin
        w_en    = 1'b1;
        w_reg1  = reg1_i;
        w_reg2  = reg2_i;
        w_imm   = imm_i;
        w_u1    = w_multi ? (w_lmw ? regWrite : regRead) : reg1Use_i;
        w_u2    = w_multi ? regRead : reg2Use_i;
        w_z     = w_multi | reg2ValOrZero_i;
        w_last  = !w_multi || reg1_i == REG_MAX;
        w_state = w_last ? IDLE : SEQ;
      end
    end
  end
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      r_state <= IDLE;
      r_en    <= 1'b0;
      r_reg1  <= '0;
      r_reg2  <= '0;
      r_u1    <= '0;
      r_u2    <= '0;
      r_z     <= 1'b0;
      r_imm   <= '0;
      r_last  <= 1'b0;
      r_ill   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_en    <= w_en;
      r_reg1  <= w_reg1;
      r_reg2  <= w_reg2;
      r_u1    <= w_u1;
      r_u2    <= w_u2;
      r_z     <= w_z;
      r_imm   <= w_imm;
      r_last  <= w_last;
      r_ill   <= w_ill;
    end
  end
endmodule

// File: tb/tb_multiple_word_sequencer.sv
// tb_multiple_word_sequencer: directed self-checking bench for the lmw/stmw sequencer
module tb_multiple_word_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, en_i, z_i, st_i, st_o, en_o, z_o, last_o, ill_o;
  logic [5:0]  op_i;
  logic [4:0]  r1_i, r2_i, r1_o, r2_o;
  logic [1:0]  u1_i, u2_i, u1_o, u2_o;
  logic [15:0] imm_i, imm_o;
  int          errs = 0, checks = 0;
  always #5 clk = ~clk;
  multiple_word_sequencer dut (
    .clock_i(clk), .reset_i(rst_n), .enable_i(en_i), .opcode_i(op_i),
    .reg1_i(r1_i), .reg2_i(r2_i), .reg1Use_i(u1_i), .reg2Use_i(u2_i),
    .reg2ValOrZero_i(z_i), .imm_i(imm_i), .stall_i(st_i), .stall_o(st_o),
    .enable_o(en_o), .reg1_o(r1_o), .reg2_o(r2_o), .reg1Use_o(u1_o),
    .reg2Use_o(u2_o), .reg2ValOrZero_o(z_o), .imm_o(imm_o),
    .lastUop_o(last_o), .illegal_o(ill_o)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [5:0] op, input logic [4:0] r1, input logic [4:0] r2, input logic [15:0] imm);
    en_i = 1'b1; op_i = op; r1_i = r1; r2_i = r2; imm_i = imm;
  endtask
  task automatic uop(input string tag, input logic [4:0] r1, input logic [15:0] imm, input logic last, input logic stall);
    chk({tag, ".en"}, en_o, 1'b1);
    chk({tag, ".reg1"}, r1_o, r1);
    chk({tag, ".imm"}, imm_o, imm);
    chk({tag, ".last"}, last_o, last);
    chk({tag, ".stall"}, st_o, stall);
  endtask
  initial begin
    rst_n = 1'b0; en_i = 1'b0; st_i = 1'b0; op_i = '0; r1_i = '0; r2_i = '0;
    u1_i = 2'd2; u2_i = 2'd1; z_i = 1'b0; imm_i = '0;
    tick();
    chk("rst.en", en_o, 0); chk("rst.reg1", r1_o, 0); chk("rst.imm", imm_o, 0);
    chk("rst.last", last_o, 0); chk("rst.ill", ill_o, 0); chk("rst.stall", st_o, 0);
    rst_n = 1'b1;
    drive(6'd14, 5'd3, 5'd1, 16'h0010);
    tick();
    uop("addi", 5'd3, 16'h0010, 1'b1, 1'b0);
    chk("addi.reg2", r2_o, 1); chk("addi.u1", u1_o, 2); chk("addi.u2", u2_o, 1); chk("addi.z", z_o, 0);
    drive(6'd46, 5'd29, 5'd1, 16'h0008);
    tick();
    en_i = 1'b0;
    uop("lmw0", 5'd29, 16'h0008, 1'b0, 1'b1);
    chk("lmw0.u1", u1_o, 2); chk("lmw0.u2", u2_o, 1); chk("lmw0.z", z_o, 1); chk("lmw0.reg2", r2_o, 1);
    tick(); uop("lmw1", 5'd30, 16'h000C, 1'b0, 1'b1);
    tick(); uop("lmw2", 5'd31, 16'h0010, 1'b1, 1'b0);
    drive(6'd47, 5'd30, 5'd0, 16'hFFFC);
    tick();
    en_i = 1'b0;
    uop("stmw0", 5'd30, 16'hFFFC, 1'b0, 1'b1);
    chk("stmw0.u1", u1_o, 1);
    tick(); uop("stmw1", 5'd31, 16'h0000, 1'b1, 1'b0);
    drive(6'd47, 5'd28, 5'd4, 16'h0100);
    tick();
    en_i = 1'b0;
    uop("stl0", 5'd28, 16'h0100, 1'b0, 1'b1);
    tick(); uop("stl1", 5'd29, 16'h0104, 1'b0, 1'b1);
    st_i = 1'b1;
    tick(); uop("stl1h", 5'd29, 16'h0104, 1'b0, 1'b1);
    tick(); uop("stl1h2", 5'd29, 16'h0104, 1'b0, 1'b1);
    st_i = 1'b0;
    tick(); uop("stl2", 5'd30, 16'h0108, 1'b0, 1'b1);
    tick(); uop("stl3", 5'd31, 16'h010C, 1'b1, 1'b0);
    tick(); chk("stl.done", en_o, 0);
    drive(6'd46, 5'd5, 5'd7, 16'h0000);
    tick();
    chk("ill.pulse", ill_o, 1); chk("ill.en", en_o, 0); chk("ill.stall", st_o, 0);
    drive(6'd14, 5'd3, 5'd1, 16'h0010);
    tick();
    en_i = 1'b0;
    chk("ill.clr", ill_o, 0);
    uop("ill.addi", 5'd3, 16'h0010, 1'b1, 1'b0);
    tick(); chk("idle.en", en_o, 0); chk("idle.reg1", r1_o, 3);
    drive(6'd46, 5'd0, 5'd0, 16'h0000);
    tick();
    en_i = 1'b0;
    uop("rs0", 5'd0, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) tick();
    uop("rs10", 5'd10, 16'h0028, 1'b0, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("rs.en", en_o, 0); chk("rs.reg1", r1_o, 0); chk("rs.imm", imm_o, 0);
    chk("rs.u1", u1_o, 0); chk("rs.z", z_o, 0); chk("rs.stall", st_o, 0);
    rst_n = 1'b1;
    tick(); chk("rs.idle", en_o, 0); chk("rs.idle.reg1", r1_o, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
